dsp_mac_seq: RTL
================

// Module: dsp_mac_seq
// PURPOSE
//  Initiator-side controller for the DSP slice: accepts (A,B) operand pairs via valid/ready and drives the slice ports.
//  Sequences OPMODE so the slice computes P = C + sum(A_k*B_k) over N_TAPS pairs.
//  Captures the slice P output into an output register with its own valid/ready handshake.
//  Sits between a sample/coefficient source and one slice configured with A0REG=0, A1REG=B1REG=MREG=PREG=OPMODEREG=1.
// PARAMETERS
//  N_TAPS   8  operand pairs per frame (>=1)
//  LAT      3  cycles from an operand issue on dsp_a/dsp_b to the matching result on dsp_p
//  OPM_DLY  1  cycles dsp_opmode lags its operands; aligns the OPMODE register with the M register
// PORTS
//  clk           in   1   clock
//  rst_n         in   1   asynchronous active-low reset
//  bias          in   48  C operand, sampled when tap 0 is accepted
//  s_valid       in   1   operand pair valid
//  s_ready       out  1   sequencer accepts operand pair
//  s_a, s_b      in   18  operands (unsigned, matching the slice multiplier)
//  dsp_a, dsp_b  out  18  to slice A, B
//  dsp_d         out  18  to slice D; constant 0 (pre-adder unused)
//  dsp_c         out  48  to slice C; latched bias
//  dsp_opmode    out  8   to slice OPMODE
//  dsp_ce        out  1   common clock enable for all slice registers
//  dsp_p         in   48  from slice P
//  dsp_carryout  in   1   from slice CARRYOUT
//  m_valid       out  1   result valid
//  m_ready       in   1   result consumer ready
//  m_data        out  48  accumulated result
//  m_ovf         out  1   carry of the final post-add
// BEHAVIOUR
//  Reset (async, any time, including mid-frame): FSM=IDLE, tap_cnt=0, drain_cnt=0, all outputs 0, dsp_opmode=8'h00.
//  dsp_ce=1 in every cycle after reset release.
//  FSM states:
//   IDLE: s_ready=1. On s_valid: issue tap 0, latch bias into dsp_c, go to ACC with tap_cnt=1.
//   ACC: s_ready=1. Each handshake issues a tap and increments tap_cnt.
//     After the issue with tap_cnt==N_TAPS-1, go to DRAIN.
//     If N_TAPS==1, IDLE goes directly to DRAIN.
//   DRAIN: s_ready=0. Count LAT cycles from the last issue. At count LAT, register dsp_p into m_data and dsp_carryout into m_ovf.
//     In the next cycle m_valid=1 and the FSM goes to OUT. m_valid therefore rises LAT+1 cycles after the last issue.
//   OUT: s_ready=0. Hold m_valid, m_data and m_ovf until m_valid&&m_ready. Then m_valid=0 and the FSM goes to IDLE.
//     Handshake and new-frame acceptance never occur in the same cycle.
//  Opmode per issued item (emitted OPM_DLY cycles after its operands; all other cycles in between emit 8'h08):
//   tap 0: 8'h0D (Z=C, X=M, add)
//   tap k>0: 8'h09 (Z=P, X=M, add)
//   bubble (ACC with s_valid=0): operands 0, 8'h08 (Z=P, X=0); P holds
//  Bit4=0 (no pre-add) and bit5=0 (carry-in 0) always.
//  Stalls: any number of bubbles in ACC leaves the result unchanged. tap_cnt counts handshakes only.
//  Arithmetic: 48-bit wrap in the slice; m_ovf reflects only the last post-add carry.
// CONFIGURATION
//  DSP_SEQ_SUB_EN defined:
//   Adds input port s_sub (1 bit, qualified by s_valid).
//   Tap with s_sub=1 sets opmode bit7: tap 0 uses 8'h8D (C-M), tap k uses 8'h89 (P-M).
//   Bubble opmode stays 8'h08.
//  DSP_SEQ_SUB_EN undefined: no s_sub port; bit7 is always 0.
// TESTING
//  N_TAPS=4, bias=10, pairs (1,2),(3,4),(5,6),(7,8) back-to-back, m_ready=1
//   -> m_data=110, m_ovf=0, m_valid exactly LAT+1 cycles after the 4th handshake.
//  Same frame with 3 idle cycles between each pair -> m_data=110; dsp_opmode=8'h08 during every bubble slot.
//  m_ready=0 for 5 cycles after m_valid -> m_data holds 110, s_ready=0 throughout; one handshake, then IDLE.
//  rst_n low after 2 taps, then a fresh frame bias=0, pairs (2,2)x4 -> m_data=16, no residue from the aborted frame.
//  bias=48'hFFFF_FFFF_FFFF, pairs (1,1),(0,0),(0,0),(0,0) -> m_data=0, m_ovf=0 (carry on tap 0 only).
//   Repeat with pair order (0,0),(0,0),(0,0),(1,1) -> m_data=0, m_ovf=1.
//  DSP_SEQ_SUB_EN: bias=100, pairs (2,3)x4 all with s_sub=1 -> m_data=76; opmodes 8'h8D,8'h89,8'h89,8'h89.

Source files
------------

// File: rtl/dsp_mac_seq.sv
// rtl/dsp_mac_seq.sv - DSP slice MAC sequencer: P = C + sum(A_k*B_k) over N_TAPS operand pairs
// Optional DSP_SEQ_SUB_EN adds s_sub, selecting per-tap subtraction through OPMODE bit 7.
`timescale 1ns/1ps
module dsp_mac_seq #(
    parameter int N_TAPS  = 8,
    parameter int LAT     = 3,
    parameter int OPM_DLY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [47:0] bias,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [17:0] s_a,
    input  logic [17:0] s_b,
`ifdef DSP_SEQ_SUB_EN
    input  logic        s_sub,
`endif
    output logic [17:0] dsp_a,
    output logic [17:0] dsp_b,
    output logic [17:0] dsp_d,
    output logic [47:0] dsp_c,
    output logic [7:0]  dsp_opmode,
    output logic        dsp_ce,
    input  logic [47:0] dsp_p,
    input  logic        dsp_carryout,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [47:0] m_data,
    output logic        m_ovf
);

    localparam int TW = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
    localparam int DW = $clog2(LAT + 1);

    localparam logic [6:0] OPM_TAP0 = 7'h0D;
    localparam logic [6:0] OPM_TAPK = 7'h09;
    localparam logic [7:0] OPM_HOLD = 8'h08;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [TW-1:0]            r_tap_cnt;
    logic [TW-1:0]            w_tap_nxt;
    logic [DW-1:0]            r_drain_cnt;
    logic                     r_s_ready;
    logic [17:0]              r_dsp_a;
    logic [17:0]              r_dsp_b;
    logic [47:0]              r_dsp_c;
    logic [OPM_DLY:0][7:0]    r_opm_pipe;
    logic                     r_ce;
    logic                     r_m_valid;
    logic [47:0]              r_m_data;
    logic                     r_m_ovf;
    logic                     w_hs;
    logic                     w_sub;
    logic                     w_capture;
    logic [7:0]               w_issue_opm;

`ifdef DSP_SEQ_SUB_EN
    assign w_sub = s_sub;
`else
    assign w_sub = 1'b0;
`endif

    // s_ready is registered from the next state so it is 0 throughout reset
    assign w_hs      = s_valid && r_s_ready;
    assign w_capture = (r_state == ST_DRAIN) && (r_drain_cnt == DW'(LAT));

    always_comb begin
        w_state_nxt = r_state;
        w_tap_nxt   = r_tap_cnt;
        w_issue_opm = OPM_HOLD;
        case (r_state)
            ST_IDLE: begin
                if (w_hs) begin
                    w_issue_opm = {w_sub, OPM_TAP0};
                    if (N_TAPS == 1) begin
                        w_state_nxt = ST_DRAIN;
                        w_tap_nxt   = '0;
                    end else begin
                        w_state_nxt = ST_ACC;
                        w_tap_nxt   = TW'(1);
                    end
                end
            end
            ST_ACC: begin
                if (w_hs) begin
                    w_issue_opm = {w_sub, OPM_TAPK};
                    if (r_tap_cnt == TW'(N_TAPS - 1)) begin
                        w_state_nxt = ST_DRAIN;
                        w_tap_nxt   = '0;
                    end else begin
                        w_tap_nxt   = r_tap_cnt + TW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (w_capture) begin
                    w_state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                if (m_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_tap_cnt   <= '0;
            r_drain_cnt <= '0;
            r_s_ready   <= 1'b0;
            r_dsp_a     <= '0;
            r_dsp_b     <= '0;
            r_dsp_c     <= '0;
            r_opm_pipe  <= '0;
            r_ce        <= 1'b0;
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
            r_m_ovf     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tap_cnt   <= w_tap_nxt;
            r_drain_cnt <= (r_state == ST_DRAIN) ? r_drain_cnt + DW'(1) : '0;
            r_s_ready   <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_ACC);
            r_ce        <= 1'b1;
            // bubbles drive zero operands so the slice multiplier sees nothing stale
            r_dsp_a     <= w_hs ? s_a : '0;
            r_dsp_b     <= w_hs ? s_b : '0;
            if (w_hs && (r_state == ST_IDLE)) begin
                r_dsp_c <= bias;
            end
            r_opm_pipe[0] <= w_issue_opm;
            for (int i = 1; i <= OPM_DLY; i++) begin
                r_opm_pipe[i] <= r_opm_pipe[i-1];
            end
            if (w_capture) begin
                r_m_valid <= 1'b1;
                r_m_data  <= dsp_p;
                r_m_ovf   <= dsp_carryout;
            end else if ((r_state == ST_OUT) && m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign s_ready    = r_s_ready;
    assign dsp_a      = r_dsp_a;
    assign dsp_b      = r_dsp_b;
    assign dsp_d      = '0;
    assign dsp_c      = r_dsp_c;
    assign dsp_opmode = r_opm_pipe[OPM_DLY];
    assign dsp_ce     = r_ce;
    assign m_valid    = r_m_valid;
    assign m_data     = r_m_data;
    assign m_ovf      = r_m_ovf;

endmodule
